// File: rtl/data_mem_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | data_mem_arbiter: round-robin arbiter serialising core MEM ops onto a    |
// | single-port synchronous data RAM.                     Revision: 1.0      |
// +--------------------------------------------------------------------------+
module data_mem_arbiter #(
  parameter int NUM_CORES = 4,
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 16,
  parameter int MEM_LAT   = 1
) (
  input  logic                        clk_i,
  input  logic                        rst_n_i,
  input  logic [2*NUM_CORES-1:0]      core_mem_op_i,
  input  logic [ADDR_W*NUM_CORES-1:0] core_addr_i,
  input  logic [DATA_W*NUM_CORES-1:0] core_wdata_i,
  output logic [NUM_CORES-1:0]        core_grant_o,
  output logic [NUM_CORES-1:0]        core_done_o,
  output logic [DATA_W-1:0]           core_rdata_o,
  output logic                        mem_en_o,
  output logic                        mem_we_o,
  output logic [ADDR_W-1:0]           mem_addr_o,
  output logic [DATA_W-1:0]           mem_wdata_o,
  input  logic [DATA_W-1:0]           mem_rdata_i
);

  localparam int             IDX_W     = $clog2(NUM_CORES);
  localparam logic [IDX_W:0] NC_EXT    = (IDX_W+1)'(NUM_CORES);
  localparam logic [3:0]     WAIT_INIT = 4'(MEM_LAT - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_WAIT   = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t                 state_q, state_d;
  logic [IDX_W-1:0]       ptr_q, ptr_d;
  logic [3:0]             cnt_q, cnt_d;
  logic [NUM_CORES-1:0]   grant_q, grant_d;
  logic [NUM_CORES-1:0]   done_q, done_d;
  logic [DATA_W-1:0]      rdata_q, rdata_d;
  logic                   mem_en_q, mem_en_d;
  logic                   mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]      mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]      mem_wdata_q, mem_wdata_d;

  logic [NUM_CORES-1:0]   req_w;
  logic [NUM_CORES-1:0]   wr_w;
  logic [ADDR_W-1:0]      addr_w  [NUM_CORES];
  logic [DATA_W-1:0]      wdata_w [NUM_CORES];

  // Ops 01/10 are requests; 00 and the reserved 11 are not.
  genvar gk;
  generate
    for (gk = 0; gk < NUM_CORES; gk++) begin : g_unpack
      assign req_w[gk]   = core_mem_op_i[2*gk] ^ core_mem_op_i[2*gk+1];
      assign wr_w[gk]    = core_mem_op_i[2*gk+1] & ~core_mem_op_i[2*gk];
      assign addr_w[gk]  = core_addr_i[ADDR_W*gk +: ADDR_W];
      assign wdata_w[gk] = core_wdata_i[DATA_W*gk +: DATA_W];
    end
  endgenerate

  logic                 found_w;
  logic [IDX_W-1:0]     sel_w;
  logic [IDX_W-1:0]     sel_next_w;

  always_comb begin
    logic [IDX_W:0] cand;
    logic [IDX_W:0] nxt;
    found_w    = 1'b0;
    sel_w      = '0;
    cand       = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      cand = {1'b0, ptr_q} + (IDX_W+1)'(i);
      if (cand >= NC_EXT) cand = cand - NC_EXT;
      if (!found_w && req_w[cand[IDX_W-1:0]]) begin
        found_w = 1'b1;
        sel_w   = cand[IDX_W-1:0];
      end
    end
    nxt = {1'b0, sel_w} + (IDX_W+1)'(1);
    if (nxt >= NC_EXT) nxt = '0;
    sel_next_w = nxt[IDX_W-1:0];
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    cnt_d       = cnt_q;
    grant_d     = grant_q;
    done_d      = done_q;
    rdata_d     = rdata_q;
    mem_en_d    = mem_en_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    case (state_q)
      S_IDLE: begin
        if (found_w) begin
          grant_d        = '0;
          grant_d[sel_w] = 1'b1;
          mem_en_d       = 1'b1;
          mem_we_d       = wr_w[sel_w];
          mem_addr_d     = addr_w[sel_w];
          mem_wdata_d    = wdata_w[sel_w];
          ptr_d          = sel_next_w;
          state_d        = S_ACCESS;
        end
      end
      S_ACCESS: begin
        mem_en_d = 1'b0;
        mem_we_d = 1'b0;
        if (mem_we_q) begin
          done_d  = grant_q;
          state_d = S_DONE;
        end else begin
          cnt_d   = WAIT_INIT;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        // RAM output becomes valid on the last wait cycle.
        if (cnt_q == 4'd0) begin
          rdata_d = mem_rdata_i;
          done_d  = grant_q;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_DONE: begin
        done_d  = '0;
        grant_d = '0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q     <= S_IDLE;
      ptr_q       <= '0;
      cnt_q       <= '0;
      grant_q     <= '0;
      done_q      <= '0;
      rdata_q     <= '0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      cnt_q       <= cnt_d;
      grant_q     <= grant_d;
      done_q      <= done_d;
      rdata_q     <= rdata_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign core_grant_o = grant_q;
  assign core_done_o  = done_q;
  assign core_rdata_o = rdata_q;
  assign mem_en_o     = mem_en_q;
  assign mem_we_o     = mem_we_q;
  assign mem_addr_o   = mem_addr_q;
  assign mem_wdata_o  = mem_wdata_q;

endmodule
`default_nettype wire

// File: tb/tb_data_mem_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_data_mem_arbiter: scoreboard bench for data_mem_arbiter.              |
// |                                                       Revision: 1.0      |
// +--------------------------------------------------------------------------+
module tb_data_mem_arbiter;

  localparam int N  = 4;
  localparam int AW = 16;
  localparam int DW = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst_n, rst3_n;
  logic [2*N-1:0]  op, op3;
  logic [AW*N-1:0] addr, addr3;
  logic [DW*N-1:0] wdata, wdata3;

  logic [N-1:0]    grant, done, grant3, done3;
  logic [DW-1:0]   rdata, rdata3;
  logic            mem_en, mem_we, mem_en3, mem_we3;
  logic [AW-1:0]   mem_addr, mem_addr3;
  logic [DW-1:0]   mem_wdata, mem_wdata3, mem_rdata, mem_rdata3;

  data_mem_arbiter #(.NUM_CORES(N), .ADDR_W(AW), .DATA_W(DW), .MEM_LAT(1)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .core_mem_op_i(op), .core_addr_i(addr),
    .core_wdata_i(wdata), .core_grant_o(grant), .core_done_o(done),
    .core_rdata_o(rdata), .mem_en_o(mem_en), .mem_we_o(mem_we),
    .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata)
  );

  data_mem_arbiter #(.NUM_CORES(N), .ADDR_W(AW), .DATA_W(DW), .MEM_LAT(3)) dut_lat3 (
    .clk_i(clk), .rst_n_i(rst3_n), .core_mem_op_i(op3), .core_addr_i(addr3),
    .core_wdata_i(wdata3), .core_grant_o(grant3), .core_done_o(done3),
    .core_rdata_o(rdata3), .mem_en_o(mem_en3), .mem_we_o(mem_we3),
    .mem_addr_o(mem_addr3), .mem_wdata_o(mem_wdata3), .mem_rdata_i(mem_rdata3)
  );

  // RAM model: RAM[a]=a, except 0x40 which starts at 0.
  logic [DW-1:0] ram [0:255];
  logic [DW-1:0] p0, p1, p2;
  initial begin
    for (int i = 0; i < 256; i++) ram[i] <= 16'(i);
    ram[8'h40] <= 16'h0000;
  end
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) ram[mem_addr[7:0]] <= mem_wdata;
      else        mem_rdata <= ram[mem_addr[7:0]];
    end
    if (mem_en3 && !mem_we3) p0 <= ram[mem_addr3[7:0]];
    p1 <= p0;
    p2 <= p1;
  end
  assign mem_rdata3 = p2;

  typedef struct { int core; logic [DW-1:0] data; } exp_t;
  exp_t sb[$];
  int checks   = 0;
  int failures = 0;

  function automatic logic [N-1:0] oh(input int k);
    oh = 4'b0001 << k;
  endfunction

  task automatic set_req(input int k, input logic [1:0] o, input logic [AW-1:0] a,
                         input logic [DW-1:0] d);
    op[2*k +: 2]     = o;
    addr[AW*k +: AW] = a;
    wdata[DW*k +: DW] = d;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; rst3_n = 1'b0;
    op = 8'b10_01_10_01; addr = {4{16'h0012}}; wdata = {4{16'hFFFF}};
    op3 = 8'b01_01_01_01; addr3 = '0; wdata3 = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (grant !== 4'b0) begin failures++; $display("FAIL reset_grant got=%h exp=0", grant); end
    checks++; if (done !== 4'b0) begin failures++; $display("FAIL reset_done got=%h exp=0", done); end
    checks++; if ({mem_en, mem_we} !== 2'b00) begin failures++; $display("FAIL reset_en_we got=%b exp=00", {mem_en, mem_we}); end
    checks++; if (mem_addr !== 16'h0) begin failures++; $display("FAIL reset_mem_addr got=%h exp=0", mem_addr); end
    checks++; if (mem_wdata !== 16'h0) begin failures++; $display("FAIL reset_mem_wdata got=%h exp=0", mem_wdata); end
    checks++; if (rdata !== 16'h0) begin failures++; $display("FAIL reset_rdata got=%h exp=0", rdata); end
    checks++; if ({grant3, done3, mem_en3} !== 9'b0) begin failures++; $display("FAIL reset_lat3 got=%h exp=0", {grant3, done3, mem_en3}); end
    op = '0; addr = '0; wdata = '0; op3 = '0;
    rst_n = 1'b1; rst3_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_write_read;
    exp_t e;
    int   lat;
    sb.delete();
    set_req(0, 2'b10, 16'h0040, 16'hBEEF);
    sb.push_back('{0, 16'hBEEF});
    @(negedge clk);
    checks++; if ({mem_en, mem_we} !== 2'b11) begin failures++; $display("FAIL wr_en_we got=%b exp=11", {mem_en, mem_we}); end
    checks++; if (mem_addr !== 16'h0040 || mem_wdata !== 16'hBEEF) begin failures++; $display("FAIL wr_addr_data got=%h/%h exp=0040/beef", mem_addr, mem_wdata); end
    checks++; if (grant !== 4'b0001 || done !== 4'b0) begin failures++; $display("FAIL wr_grant got=%b/%b exp=0001/0000", grant, done); end
    @(negedge clk);
    e = sb.pop_front();
    checks++; if (done !== oh(e.core)) begin failures++; $display("FAIL wr_done got=%b exp=%b", done, oh(e.core)); end
    set_req(0, 2'b00, 16'h0, 16'h0);
    @(negedge clk);
    set_req(0, 2'b01, 16'h0040, 16'h0);
    sb.push_back('{0, 16'hBEEF});
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (done === 4'b0 && lat < 10);
    e = sb.pop_front();
    checks++; if (lat != 3) begin failures++; $display("FAIL rd_latency got=%0d exp=3", lat); end
    checks++; if (done !== oh(e.core)) begin failures++; $display("FAIL rd_done got=%b exp=%b", done, oh(e.core)); end
    checks++; if (rdata !== e.data) begin failures++; $display("FAIL rd_data got=%h exp=%h", rdata, e.data); end
    set_req(0, 2'b00, 16'h0, 16'h0);
    @(negedge clk);
  endtask

  task automatic test_all_cores;
    exp_t e;
    int   last;
    sb.delete();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < N; k++) begin
      set_req(k, 2'b01, 16'(16'h0010 + k), 16'h0);
      sb.push_back('{k, 16'(16'h0010 + k)});
    end
    last = -1;
    for (int c = 0; c < 60 && sb.size() > 0; c++) begin
      @(negedge clk);
      checks++; if ($countones(grant) > 1 || (done & ~grant) != 0) begin failures++; $display("FAIL all_onehot grant=%b done=%b", grant, done); end
      if (done !== 4'b0) begin
        e = sb.pop_front();
        checks++; if (done !== oh(e.core)) begin failures++; $display("FAIL all_order got=%b exp=%b", done, oh(e.core)); end
        checks++; if (rdata !== e.data) begin failures++; $display("FAIL all_rdata got=%h exp=%h", rdata, e.data); end
        if (last >= 0) begin
          checks++; if (c - last != 4) begin failures++; $display("FAIL all_spacing got=%0d exp=4", c - last); end
        end
        last = c;
        set_req(e.core, 2'b00, 16'h0, 16'h0);
      end
    end
    checks++; if (sb.size() != 0) begin failures++; $display("FAIL all_timeout pending=%0d exp=0", sb.size()); end
    @(negedge clk);
  endtask

  task automatic test_pointer;
    exp_t e;
    bit   re;
    sb.delete();
    re = 1'b0;
    set_req(1, 2'b01, 16'h0021, 16'h0);
    sb.push_back('{1, 16'h0021});
    for (int c = 0; c < 60 && sb.size() > 0; c++) begin
      @(negedge clk);
      if (done !== 4'b0) begin
        e = sb.pop_front();
        checks++; if (done !== oh(e.core)) begin failures++; $display("FAIL ptr_order got=%b exp=%b", done, oh(e.core)); end
        checks++; if (rdata !== e.data) begin failures++; $display("FAIL ptr_rdata got=%h exp=%h", rdata, e.data); end
        if (e.core == 1) begin
          set_req(1, 2'b00, 16'h0, 16'h0);
          set_req(0, 2'b01, 16'h0030, 16'h0);
          set_req(3, 2'b01, 16'h0033, 16'h0);
          sb.push_back('{3, 16'h0033});
          sb.push_back('{0, 16'h0030});
        end else if (e.core == 3 && !re) begin
          set_req(3, 2'b01, 16'h0053, 16'h0);
          sb.push_back('{3, 16'h0053});
          re = 1'b1;
        end else begin
          set_req(e.core, 2'b00, 16'h0, 16'h0);
        end
      end
    end
    checks++; if (sb.size() != 0) begin failures++; $display("FAIL ptr_timeout pending=%0d exp=0", sb.size()); end
    @(negedge clk);
  endtask

  task automatic test_reserved;
    set_req(1, 2'b11, 16'h0005, 16'h0005);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      checks++; if ({mem_en, grant, done} !== 9'b0) begin failures++; $display("FAIL reserved_idle got=%b exp=0", {mem_en, grant, done}); end
    end
    set_req(1, 2'b00, 16'h0, 16'h0);
    @(negedge clk);
  endtask

  task automatic test_addr_change;
    exp_t e;
    int   c;
    sb.delete();
    set_req(2, 2'b01, 16'h0077, 16'hAAAA);
    sb.push_back('{2, 16'h0077});
    c = 0;
    while (sb.size() > 0 && c < 40) begin
      @(negedge clk);
      c++;
      if (c == 2) begin
        checks++; if (mem_addr !== 16'h0077) begin failures++; $display("FAIL chg_addr_wait got=%h exp=0077", mem_addr); end
        set_req(2, 2'b01, 16'h0099, 16'h5555);
      end
      if (done !== 4'b0) begin
        e = sb.pop_front();
        checks++; if (done !== oh(e.core)) begin failures++; $display("FAIL chg_done got=%b exp=%b", done, oh(e.core)); end
        checks++; if (rdata !== e.data) begin failures++; $display("FAIL chg_rdata got=%h exp=%h", rdata, e.data); end
        if (e.core == 2) begin
          checks++; if (mem_addr !== 16'h0077 || mem_wdata !== 16'hAAAA) begin failures++; $display("FAIL chg_latched got=%h/%h exp=0077/aaaa", mem_addr, mem_wdata); end
          set_req(2, 2'b00, 16'h0, 16'h0);
          // A following write must leave the read data untouched.
          set_req(1, 2'b10, 16'h0041, 16'h1234);
          sb.push_back('{1, 16'h0077});
        end else begin
          set_req(e.core, 2'b00, 16'h0, 16'h0);
        end
      end
    end
    checks++; if (sb.size() != 0) begin failures++; $display("FAIL chg_timeout pending=%0d exp=0", sb.size()); end
    @(negedge clk);
  endtask

  task automatic test_reset_wait;
    exp_t e;
    sb.delete();
    op3[5:4] = 2'b01; addr3[32 +: 16] = 16'h0055;
    @(negedge clk);
    checks++; if (mem_en3 !== 1'b1 || grant3 !== 4'b0100) begin failures++; $display("FAIL rw_access got=%b/%b exp=1/0100", mem_en3, grant3); end
    @(negedge clk);
    checks++; if (mem_en3 !== 1'b0 || grant3 !== 4'b0100) begin failures++; $display("FAIL rw_wait1 got=%b/%b exp=0/0100", mem_en3, grant3); end
    @(negedge clk);
    rst3_n = 1'b0;
    op3[1:0] = 2'b01; addr3[0 +: 16] = 16'h0020;
    @(negedge clk);
    checks++; if ({grant3, done3, mem_en3, mem_we3} !== 10'b0) begin failures++; $display("FAIL rw_ctrl_zero got=%b exp=0", {grant3, done3, mem_en3, mem_we3}); end
    checks++; if ({mem_addr3, mem_wdata3, rdata3} !== 48'h0) begin failures++; $display("FAIL rw_data_zero got=%h exp=0", {mem_addr3, mem_wdata3, rdata3}); end
    rst3_n = 1'b1;
    @(negedge clk);
    checks++; if (grant3 !== 4'b0001 || done3 !== 4'b0) begin failures++; $display("FAIL rw_regrant got=%b/%b exp=0001/0000", grant3, done3); end
    sb.push_back('{0, 16'h0020});
    sb.push_back('{2, 16'h0055});
    for (int c = 0; c < 40 && sb.size() > 0; c++) begin
      @(negedge clk);
      if (done3 !== 4'b0) begin
        e = sb.pop_front();
        checks++; if (done3 !== oh(e.core)) begin failures++; $display("FAIL rw_done got=%b exp=%b", done3, oh(e.core)); end
        checks++; if (rdata3 !== e.data) begin failures++; $display("FAIL rw_rdata got=%h exp=%h", rdata3, e.data); end
        op3[2*e.core +: 2] = 2'b00;
      end
    end
    checks++; if (sb.size() != 0) begin failures++; $display("FAIL rw_timeout pending=%0d exp=0", sb.size()); end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_all_cores();
    test_pointer();
    test_reserved();
    test_addr_change();
    test_reset_wait();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
